// File: rtl/pcileech_bar_access_sched.sv
// pcileech_bar_access_sched: in-order single-issue scheduler between the TLP BAR engine and one BAR
// implementation, with read-outstanding throttling and a quiesce handshake.
module pcileech_bar_access_sched #(
   parameter int DEPTH      = 8,
   parameter int MAX_RD_OUT = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [31:0]             in_wr_addr,
   input  logic [3:0]              in_wr_be,
   input  logic [31:0]             in_wr_data,
   input  logic                    in_wr_valid,
   input  logic [87:0]             in_rd_ctx,
   input  logic [31:0]             in_rd_addr,
   input  logic                    in_rd_valid,
   output logic [31:0]             bar_wr_addr,
   output logic [3:0]              bar_wr_be,
   output logic [31:0]             bar_wr_data,
   output logic                    bar_wr_valid,
   output logic [87:0]             bar_rd_ctx,
   output logic [31:0]             bar_rd_addr,
   output logic                    bar_rd_valid,
   input  logic                    bar_rsp_valid,
   input  logic                    quiesce_req,
   output logic                    quiesce_ack,
   output logic                    ovf_sticky,
   output logic [15:0]             drop_cnt,
   output logic [$clog2(DEPTH):0]  level
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL = DEPTH[AW:0];
   localparam logic [3:0] MAXR = MAX_RD_OUT[3:0];
   localparam logic [1:0] RUN = 2'd0, HOLD = 2'd1, QUIET = 2'd2;
   logic          m_rd   [DEPTH];
   logic [31:0]   m_addr [DEPTH];
   logic [3:0]    m_be   [DEPTH];
   logic [31:0]   m_data [DEPTH];
   logic [87:0]   m_ctx  [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr, rd_slot;
   logic [AW:0]   free;
   logic [3:0]    rd_out;
   logic [1:0]    state, state_nx, n_push, n_drop;
   logic          wr_ok, rd_ok, push_any, head_rd, pop;
   // The write claims the first free slot, so with one slot left the read is the one dropped.
   always_comb begin
      free     = FULL - level;
      wr_ok    = in_wr_valid && free != '0;
      rd_ok    = in_rd_valid && free > {{AW{1'b0}}, wr_ok};
      n_push   = {1'b0, wr_ok} + {1'b0, rd_ok};
      n_drop   = {1'b0, in_wr_valid & ~wr_ok} + {1'b0, in_rd_valid & ~rd_ok};
      push_any = wr_ok | rd_ok;
      rd_slot  = wr_ptr + AW'(wr_ok);
      head_rd  = m_rd[rd_ptr];
      pop      = state == RUN && !quiesce_req && level != '0 && !(head_rd && rd_out == MAXR);
      state_nx = state == RUN  ? (quiesce_req ? HOLD : RUN) :
                 state == HOLD ? (!quiesce_req ? RUN :
                                  (level == '0 && rd_out == '0 && !push_any) ? QUIET : HOLD) :
                                 (!quiesce_req ? RUN : push_any ? HOLD : QUIET);
   end
   always_ff @(posedge clk) begin
      if (wr_ok) begin
         m_rd[wr_ptr]   <= 1'b0;
         m_addr[wr_ptr] <= in_wr_addr;
         m_be[wr_ptr]   <= in_wr_be;
         m_data[wr_ptr] <= in_wr_data;
         m_ctx[wr_ptr]  <= '0;
      end
      if (rd_ok) begin
         m_rd[rd_slot]   <= 1'b1;
         m_addr[rd_slot] <= in_rd_addr;
         m_be[rd_slot]   <= '0;
         m_data[rd_slot] <= '0;
         m_ctx[rd_slot]  <= in_rd_ctx;
      end
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         level        <= '0;
         rd_out       <= '0;
         state        <= RUN;
         quiesce_ack  <= 1'b0;
         ovf_sticky   <= 1'b0;
         drop_cnt     <= '0;
         bar_wr_valid <= 1'b0;
         bar_rd_valid <= 1'b0;
         bar_wr_addr  <= '0;
         bar_wr_be    <= '0;
         bar_wr_data  <= '0;
         bar_rd_addr  <= '0;
         bar_rd_ctx   <= '0;
      end else begin
         wr_ptr       <= wr_ptr + AW'(n_push);
         rd_ptr       <= rd_ptr + AW'(pop);
         level        <= level + {{(AW-1){1'b0}}, n_push} - {{AW{1'b0}}, pop};
         rd_out       <= rd_out + {3'b0, pop && head_rd} - {3'b0, bar_rsp_valid && rd_out != '0};
         state        <= state_nx;
         quiesce_ack  <= state_nx == QUIET;
         ovf_sticky   <= ovf_sticky | (n_drop != '0);
         drop_cnt     <= drop_cnt > 16'hFFFF - {14'b0, n_drop} ? 16'hFFFF : drop_cnt + {14'b0, n_drop};
         bar_wr_valid <= pop && !head_rd;
         bar_rd_valid <= pop && head_rd;
         if (pop && !head_rd) begin
            bar_wr_addr <= m_addr[rd_ptr];
            bar_wr_be   <= m_be[rd_ptr];
            bar_wr_data <= m_data[rd_ptr];
         end
         if (pop && head_rd) begin
            bar_rd_addr <= m_addr[rd_ptr];
            bar_rd_ctx  <= m_ctx[rd_ptr];
         end
      end
   end
endmodule

// File: tb/tb_pcileech_bar_access_sched.sv
// tb_pcileech_bar_access_sched: scoreboard bench; the driver pushes expected commands into a queue
// and a monitor compares every issued BAR access, occupancy, drop counters and quiesce_ack.
module tb_pcileech_bar_access_sched;
   localparam int DEPTH = 8, MAXR = 4;
   logic clk = 0, rst_n = 0;
   always #5 clk = ~clk;
   logic [31:0] in_wr_addr = 0, in_wr_data = 0, in_rd_addr = 0;
   logic [3:0]  in_wr_be = 0;
   logic [87:0] in_rd_ctx = 0;
   logic        in_wr_valid = 0, in_rd_valid = 0, bar_rsp_valid = 0, quiesce_req = 0;
   logic [31:0] bar_wr_addr, bar_wr_data, bar_rd_addr;
   logic [3:0]  bar_wr_be;
   logic [87:0] bar_rd_ctx;
   logic        bar_wr_valid, bar_rd_valid, quiesce_ack, ovf_sticky;
   logic [15:0] drop_cnt;
   logic [3:0]  level;

   pcileech_bar_access_sched #(.DEPTH(DEPTH), .MAX_RD_OUT(MAXR)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_wr_addr(in_wr_addr), .in_wr_be(in_wr_be), .in_wr_data(in_wr_data), .in_wr_valid(in_wr_valid),
      .in_rd_ctx(in_rd_ctx), .in_rd_addr(in_rd_addr), .in_rd_valid(in_rd_valid),
      .bar_wr_addr(bar_wr_addr), .bar_wr_be(bar_wr_be), .bar_wr_data(bar_wr_data), .bar_wr_valid(bar_wr_valid),
      .bar_rd_ctx(bar_rd_ctx), .bar_rd_addr(bar_rd_addr), .bar_rd_valid(bar_rd_valid),
      .bar_rsp_valid(bar_rsp_valid), .quiesce_req(quiesce_req), .quiesce_ack(quiesce_ack),
      .ovf_sticky(ovf_sticky), .drop_cnt(drop_cnt), .level(level));

   typedef struct {
      logic        is_rd;
      logic [31:0] addr;
      logic [3:0]  be;
      logic [31:0] data;
      logic [87:0] ctx;
   } cmd_t;
   cmd_t exp_q[$];
   cmd_t c;
   int   n_cmp = 0, n_bad = 0, drops_m = 0, rd_out_m = 0, pre_cnt = 0, rd_seen = 0;
   logic pre_rd = 0, pre_push = 0, q_prev = 0, exp_pop, ack_e;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // One call per clock: drives inputs for the next edge and records what the FIFO will accept.
   task automatic drive(input logic wv, input logic [31:0] wa, input logic [3:0] wb, input logic [31:0] wd,
                        input logic rv, input logic [31:0] ra, input logic [87:0] rc,
                        input logic rsp, input logic q);
      int   room;
      cmd_t e;
      @(negedge clk);
      in_wr_valid = wv; in_wr_addr = wa; in_wr_be = wb; in_wr_data = wd;
      in_rd_valid = rv; in_rd_addr = ra; in_rd_ctx = rc;
      bar_rsp_valid = rsp; quiesce_req = q;
      pre_cnt  = exp_q.size();
      pre_rd   = 0;
      if (pre_cnt > 0) pre_rd = exp_q[0].is_rd;
      pre_push = 0;
      room     = DEPTH - pre_cnt;
      if (wv) begin
         if (room > 0) begin
            e.is_rd = 0; e.addr = wa; e.be = wb; e.data = wd; e.ctx = '0;
            exp_q.push_back(e); room--; pre_push = 1;
         end else drops_m++;
      end
      if (rv) begin
         if (room > 0) begin
            e.is_rd = 1; e.addr = ra; e.be = '0; e.data = '0; e.ctx = rc;
            exp_q.push_back(e); room--; pre_push = 1;
         end else drops_m++;
      end
   endtask

   task automatic idle(input int n, input logic rsp, input logic q);
      for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0, rsp, q);
   endtask

   task automatic model_reset();
      exp_q.delete();
      drops_m = 0; rd_out_m = 0; pre_cnt = 0; pre_rd = 0; pre_push = 0;
   endtask

   // Issue rule: head leaves when present, quiesce low for this and the previous edge, and not read-throttled.
   always @(posedge clk) begin
      #1;
      if (!rst_n) q_prev = 0;
      else begin
         exp_pop = pre_cnt > 0 && !quiesce_req && !q_prev && !(pre_rd && rd_out_m == MAXR);
         ack_e   = quiesce_req && q_prev && pre_cnt == 0 && rd_out_m == 0 && !pre_push;
         chk("single_issue", bar_wr_valid & bar_rd_valid, 0);
         chk("issue", bar_wr_valid | bar_rd_valid, exp_pop);
         chk("quiesce_ack", quiesce_ack, ack_e);
         if ((bar_wr_valid | bar_rd_valid) && exp_q.size() > 0) begin
            c = exp_q.pop_front();
            chk("kind", bar_rd_valid, c.is_rd);
            if (c.is_rd) chk("rd_fields", {bar_rd_addr, bar_rd_ctx}, {c.addr, c.ctx});
            else chk("wr_fields", {bar_wr_addr, bar_wr_be, bar_wr_data}, {c.addr, c.be, c.data});
         end
         rd_seen  += int'(bar_rd_valid);
         rd_out_m += int'(bar_rd_valid) - int'(bar_rsp_valid && rd_out_m > 0);
         q_prev    = quiesce_req;
         chk("level", level, exp_q.size());
         chk("drop_cnt", drop_cnt, drops_m > 65535 ? 65535 : drops_m);
         chk("ovf_sticky", ovf_sticky, drops_m > 0);
      end
   end

   initial begin
      idle(3, 0, 0);
      chk("rst_valids", {bar_wr_valid, bar_rd_valid, quiesce_ack, ovf_sticky}, 0);
      chk("rst_level_drop", {level, drop_cnt}, 0);
      rst_n = 1;
      // write only
      drive(1, 32'h6800, 4'hF, 32'h12345678, 0, 0, 0, 0, 0);
      idle(1, 0, 0);
      chk("t1_not_yet", bar_wr_valid, 0);
      idle(1, 0, 0);
      chk("t1_wr", {bar_wr_valid, bar_rd_valid, bar_wr_addr, bar_wr_be, bar_wr_data},
          {1'b1, 1'b0, 32'h6800, 4'hF, 32'h12345678});
      // write and read together
      drive(1, 32'h4C00, 4'hF, 32'hA5, 1, 32'h4C00, 88'h1, 0, 0);
      idle(2, 0, 0);
      chk("t2_wr_first", {bar_wr_valid, bar_rd_valid, bar_wr_data}, {1'b1, 1'b0, 32'hA5});
      idle(1, 0, 0);
      chk("t2_rd_second", {bar_wr_valid, bar_rd_valid, bar_rd_addr, bar_rd_ctx}, {1'b0, 1'b1, 32'h4C00, 88'h1});
      idle(2, 1, 0);
      // overflow while quiesced
      idle(2, 0, 1);
      for (int i = 0; i < 9; i++) drive(1, 32'h1000 + 32'(i * 4), 4'hF, 32'(i) * 32'h01010101, 0, 0, 0, 0, 1);
      idle(1, 0, 1);
      chk("t3_level", level, 8);
      chk("t3_drop", {ovf_sticky, drop_cnt}, {1'b1, 16'd1});
      idle(12, 0, 0);
      chk("t3_drained", level, 0);
      // read throttle
      rd_seen = 0;
      for (int i = 0; i < 6; i++) drive(0, 0, 0, 0, 1, 32'h2000 + 32'(i * 4), 88'(i + 10), 0, 0);
      idle(4, 0, 0);
      chk("t4_reads", rd_seen, 4);
      chk("t4_level", level, 2);
      idle(1, 1, 0);
      idle(1, 0, 0);
      chk("t4_still_stalled", bar_rd_valid, 0);
      idle(1, 0, 0);
      chk("t4_fifth", {bar_rd_valid, bar_rd_ctx}, {1'b1, 88'd14});
      idle(8, 1, 0);
      // quiesce with two reads outstanding
      drive(0, 0, 0, 0, 1, 32'h3000, 88'hAA, 0, 0);
      drive(0, 0, 0, 0, 1, 32'h3004, 88'hBB, 0, 0);
      idle(3, 0, 0);
      idle(3, 0, 1);
      chk("t5_ack_wait", quiesce_ack, 0);
      drive(0, 0, 0, 0, 0, 0, 0, 1, 1);
      idle(1, 0, 1);
      chk("t5_ack_one_left", quiesce_ack, 0);
      drive(0, 0, 0, 0, 0, 0, 0, 1, 1);
      idle(1, 0, 1);
      chk("t5_ack_not_same", quiesce_ack, 0);
      idle(1, 0, 1);
      chk("t5_ack", quiesce_ack, 1);
      idle(2, 0, 0);
      chk("t5_ack_drop", quiesce_ack, 0);
      // asynchronous reset mid-stream
      for (int i = 0; i < 3; i++) drive(0, 0, 0, 0, 1, 32'h5000 + 32'(i), 88'(i), 0, 0);
      idle(4, 0, 0);
      for (int i = 0; i < 5; i++) drive(1, 32'h6000 + 32'(i), 4'h3, 32'(i), 0, 0, 0, 0, 1);
      idle(1, 0, 1);
      chk("t6_level", level, 5);
      drive(1, 32'h6100, 4'h1, 32'h1, 1, 32'h6200, 88'h2, 0, 1);
      @(posedge clk);
      #3 rst_n = 0;
      #1;
      chk("t6_valids", {bar_wr_valid, bar_rd_valid, quiesce_ack, ovf_sticky}, 0);
      chk("t6_level_drop", {level, drop_cnt}, 0);
      model_reset();
      idle(2, 0, 0);
      rst_n = 1;
      idle(2, 1, 0);
      // randomized traffic with occasional quiesce windows
      for (int i = 0; i < 600; i++)
         drive(1'($urandom), $urandom, 4'($urandom), $urandom, 1'($urandom), $urandom,
               {$urandom, $urandom, 24'($urandom)}, $urandom_range(0, 3) == 0, (i % 64) >= 52);
      idle(40, 1, 0);
      chk("final_level", level, 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
